// File: rtl/hazard_pkg.sv
// Shared encodings for the pipeline hazard/forwarding controller.
package hazard_pkg;

  localparam int unsigned RA_W = 5;
  typedef logic [RA_W-1:0] reg_addr_t;

  typedef enum logic [1:0] {
    FWD_REG = 2'b00,
    FWD_W   = 2'b01,
    FWD_M   = 2'b10
  } fwd_sel_t;

  localparam logic [1:0] RES_LOAD = 2'b01;

  // M result is younger than W, so it wins when both match.
  function automatic logic [1:0] fwd_select(input logic hit_m, input logic hit_w);
    fwd_sel_t sel;
    sel = FWD_REG;
    if (hit_m) begin
      sel = FWD_M;
    end else if (hit_w) begin
      sel = FWD_W;
    end
    return sel;
  endfunction

endpackage

// File: rtl/hazard_scoreboard_if.sv
// Pipeline <-> hazard unit signal bundle; master is the pipeline, slave the hazard unit.
interface hazard_scoreboard_if #(
  parameter int unsigned NUM_SRC = 2,
  parameter int unsigned REG_AW  = 5
);
  logic [NUM_SRC*REG_AW-1:0] rs_d;
  logic [REG_AW-1:0]         rd_d;
  logic                      regwrite_d;
  logic                      mdu_op_d;
  logic [NUM_SRC*REG_AW-1:0] rs_e;
  logic [REG_AW-1:0]         rd_e;
  logic                      regwrite_e;
  logic [1:0]                result_src_e;
  logic                      mdu_start_e;
  logic [1:0]                pc_src_e;
  logic [REG_AW-1:0]         rd_m;
  logic                      regwrite_m;
  logic [REG_AW-1:0]         rd_w;
  logic                      regwrite_w;
  logic                      stall_f;
  logic                      stall_d;
  logic                      flush_d;
  logic                      flush_e;
  logic [NUM_SRC*2-1:0]      fwd_e;
  logic                      mdu_wb_valid;
  logic [REG_AW-1:0]         mdu_wb_rd;
  logic                      mdu_busy;

  modport master (
    output rs_d, rd_d, regwrite_d, mdu_op_d,
    output rs_e, rd_e, regwrite_e, result_src_e, mdu_start_e, pc_src_e,
    output rd_m, regwrite_m, rd_w, regwrite_w,
    input  stall_f, stall_d, flush_d, flush_e, fwd_e,
    input  mdu_wb_valid, mdu_wb_rd, mdu_busy
  );

  modport slave (
    input  rs_d, rd_d, regwrite_d, mdu_op_d,
    input  rs_e, rd_e, regwrite_e, result_src_e, mdu_start_e, pc_src_e,
    input  rd_m, regwrite_m, rd_w, regwrite_w,
    output stall_f, stall_d, flush_d, flush_e, fwd_e,
    output mdu_wb_valid, mdu_wb_rd, mdu_busy
  );
endinterface

// File: rtl/hazard_scoreboard_mdu.sv
// Pending-register scoreboard for the fixed-latency MDU: latency counter,
// per-register pending bits and the destination of the in-flight op.
module mdu_scoreboard
  import hazard_pkg::*;
#(
  parameter int unsigned NUM_SRC = 2,
  parameter int unsigned REG_AW  = 5,
  parameter int unsigned MDU_LAT = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_SRC*REG_AW-1:0] rs_d,
  input  logic [REG_AW-1:0]         rd_d,
  input  logic                      regwrite_d,
  input  logic                      mdu_op_d,
  input  logic [REG_AW-1:0]         rd_e,
  input  logic                      regwrite_e,
  input  logic                      mdu_start_e,
  output logic                      mdu_raw,
  output logic                      mdu_waw,
  output logic                      mdu_struct,
  output logic                      mdu_wb_valid,
  output logic [REG_AW-1:0]         mdu_wb_rd,
  output logic                      mdu_busy
);

  localparam int unsigned CNT_W  = $clog2(MDU_LAT + 1);
  localparam int unsigned NREG   = 1 << REG_AW;
  // The start cycle is the first of the MDU_LAT cycles, so write-back
  // lands MDU_LAT-1 cycles after start when the counter reads 1.
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MDU_LAT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [NREG-1:0]   pend_q, pend_d;
  logic [REG_AW-1:0] wb_rd_q, wb_rd_d;
  logic              start;

  always_comb begin
    start   = mdu_start_e && (cnt_q == '0);
    cnt_d   = cnt_q;
    pend_d  = pend_q;
    wb_rd_d = wb_rd_q;
    if (cnt_q != '0) begin
      cnt_d = cnt_q - CNT_ONE;
    end else if (start) begin
      cnt_d   = CNT_LOAD;
      wb_rd_d = rd_e;
    end
    if (cnt_q == CNT_ONE) begin
      pend_d[wb_rd_q] = 1'b0;
    end
    if (start && regwrite_e && (rd_e != '0)) begin
      pend_d[rd_e] = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q   <= '0;
      pend_q  <= '0;
      wb_rd_q <= '0;
    end else begin
      cnt_q   <= cnt_d;
      pend_q  <= pend_d;
      wb_rd_q <= wb_rd_d;
    end
  end

  always_comb begin
    mdu_raw = 1'b0;
    for (int unsigned i = 0; i < NUM_SRC; i++) begin
      if ((rs_d[i*REG_AW +: REG_AW] != '0) && pend_q[rs_d[i*REG_AW +: REG_AW]]) begin
        mdu_raw = 1'b1;
      end
    end
  end

  assign mdu_waw      = regwrite_d && (rd_d != '0) && pend_q[rd_d];
  assign mdu_struct   = mdu_op_d && (cnt_q > CNT_ONE);
  assign mdu_wb_valid = (cnt_q == CNT_ONE);
  assign mdu_wb_rd    = wb_rd_q;
  assign mdu_busy     = (cnt_q != '0);

endmodule

// File: rtl/hazard_scoreboard.sv
// Hazard and forwarding controller for the 5-stage pipeline with an MDU
// scoreboard: forwarding selects, load-use / MDU interlocks, stalls and flushes.
module hazard_scoreboard
  import hazard_pkg::*;
#(
  parameter int unsigned NUM_SRC = 2,
  parameter int unsigned REG_AW  = 5,
  parameter int unsigned MDU_LAT = 4
) (
  input logic               clk,
  input logic               rst,
  hazard_scoreboard_if.slave hz
);

  logic [NUM_SRC*2-1:0] fwd_raw;
  logic                 lw_stall;
  logic                 mdu_raw, mdu_waw, mdu_struct;
  logic                 stall, redirect;

  for (genvar i = 0; i < NUM_SRC; i++) begin : g_fwd
    logic [REG_AW-1:0] rs;
    logic              hit_m, hit_w;
    assign rs    = hz.rs_e[i*REG_AW +: REG_AW];
    assign hit_m = hz.regwrite_m && (rs != '0) && (rs == hz.rd_m);
    assign hit_w = hz.regwrite_w && (rs != '0) && (rs == hz.rd_w);
    assign fwd_raw[i*2 +: 2] = fwd_select(hit_m, hit_w);
  end

  always_comb begin
    lw_stall = 1'b0;
    if ((hz.result_src_e == RES_LOAD) && hz.regwrite_e && (hz.rd_e != '0)) begin
      for (int unsigned i = 0; i < NUM_SRC; i++) begin
        if (hz.rs_d[i*REG_AW +: REG_AW] == hz.rd_e) begin
          lw_stall = 1'b1;
        end
      end
    end
  end

  mdu_scoreboard #(
    .NUM_SRC (NUM_SRC),
    .REG_AW  (REG_AW),
    .MDU_LAT (MDU_LAT)
  ) u_mdu (
    .clk          (clk),
    .rst          (rst),
    .rs_d         (hz.rs_d),
    .rd_d         (hz.rd_d),
    .regwrite_d   (hz.regwrite_d),
    .mdu_op_d     (hz.mdu_op_d),
    .rd_e         (hz.rd_e),
    .regwrite_e   (hz.regwrite_e),
    .mdu_start_e  (hz.mdu_start_e),
    .mdu_raw      (mdu_raw),
    .mdu_waw      (mdu_waw),
    .mdu_struct   (mdu_struct),
    .mdu_wb_valid (hz.mdu_wb_valid),
    .mdu_wb_rd    (hz.mdu_wb_rd),
    .mdu_busy     (hz.mdu_busy)
  );

  // While in reset the pipeline is held empty: flush D/E, never stall.
  always_comb begin
    stall      = lw_stall | mdu_raw | mdu_waw | mdu_struct;
    redirect   = |hz.pc_src_e;
    hz.stall_f = !rst && stall;
    hz.stall_d = !rst && stall;
    hz.flush_d = rst || redirect;
    hz.flush_e = rst || stall || redirect;
    hz.fwd_e   = rst ? '0 : fwd_raw;
  end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench for hazard_scoreboard: combinational vector table plus
// multi-cycle MDU sequences (RAW, structural, WAW+branch, reset mid-op).
module tb_hazard_scoreboard;
  import hazard_pkg::*;

  localparam int unsigned NS  = 2;
  localparam int unsigned AW  = 5;
  localparam int unsigned LAT = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  hazard_scoreboard_if #(.NUM_SRC(NS), .REG_AW(AW)) hz ();

  hazard_scoreboard #(.NUM_SRC(NS), .REG_AW(AW), .MDU_LAT(LAT)) dut (
    .clk (clk),
    .rst (rst),
    .hz  (hz.slave)
  );

  int n_tests = 0;
  int n_fail  = 0;

  always @(posedge clk) begin
    if (!rst) begin
      assert (!(hz.mdu_start_e && hz.mdu_busy))
        else $error("mdu_start_e driven while MDU busy");
    end
  end

  typedef struct {
    logic [9:0] rs_d;
    logic [4:0] rd_d;
    logic       rwd;
    logic       mdud;
    logic [9:0] rs_e;
    logic [4:0] rd_e;
    logic       rwe;
    logic [1:0] rse;
    logic [1:0] pcs;
    logic [4:0] rd_m;
    logic       rwm;
    logic [4:0] rd_w;
    logic       rww;
    logic       e_stall;
    logic       e_fd;
    logic       e_fe;
    logic [3:0] e_fwd;
  } vec_t;

  vec_t vecs[14];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_ctl(input string tag, input logic s, input logic fd, input logic fe);
    check({tag, " stall_f"}, 32'(hz.stall_f), 32'(s));
    check({tag, " stall_d"}, 32'(hz.stall_d), 32'(s));
    check({tag, " flush_d"}, 32'(hz.flush_d), 32'(fd));
    check({tag, " flush_e"}, 32'(hz.flush_e), 32'(fe));
  endtask

  task automatic idle();
    hz.rs_d = '0; hz.rd_d = '0; hz.regwrite_d = 1'b0; hz.mdu_op_d = 1'b0;
    hz.rs_e = '0; hz.rd_e = '0; hz.regwrite_e = 1'b0; hz.result_src_e = '0;
    hz.mdu_start_e = 1'b0; hz.pc_src_e = '0;
    hz.rd_m = '0; hz.regwrite_m = 1'b0; hz.rd_w = '0; hz.regwrite_w = 1'b0;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic start_mdu(input logic [4:0] rd);
    next_cycle();
    idle();
    hz.mdu_start_e = 1'b1;
    hz.rd_e        = rd;
    hz.regwrite_e  = 1'b1;
    #1;
  endtask

  initial begin
    vecs[0]  = '{10'd0, 5'd0, 1'b0, 1'b0, {5'd0, 5'd5}, 5'd0, 1'b0, 2'b00, 2'b00, 5'd5, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, 4'b0010};
    vecs[1]  = '{10'd0, 5'd0, 1'b0, 1'b0, {5'd0, 5'd0}, 5'd0, 1'b0, 2'b00, 2'b00, 5'd5, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, 4'b0000};
    vecs[2]  = '{10'd0, 5'd0, 1'b0, 1'b0, {5'd6, 5'd5}, 5'd0, 1'b0, 2'b00, 2'b00, 5'd5, 1'b1, 5'd6, 1'b1, 1'b0, 1'b0, 1'b0, 4'b0110};
    vecs[3]  = '{10'd0, 5'd0, 1'b0, 1'b0, {5'd5, 5'd5}, 5'd0, 1'b0, 2'b00, 2'b00, 5'd5, 1'b0, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, 4'b0101};
    vecs[4]  = '{10'd0, 5'd0, 1'b0, 1'b0, {5'd3, 5'd3}, 5'd0, 1'b0, 2'b00, 2'b00, 5'd3, 1'b1, 5'd4, 1'b1, 1'b0, 1'b0, 1'b0, 4'b1010};
    vecs[5]  = '{10'd0, 5'd0, 1'b0, 1'b0, {5'd5, 5'd5}, 5'd0, 1'b0, 2'b00, 2'b00, 5'd5, 1'b0, 5'd5, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0000};
    vecs[6]  = '{{5'd7, 5'd2}, 5'd0, 1'b0, 1'b0, 10'd0, 5'd7, 1'b1, 2'b01, 2'b00, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b1, 4'b0000};
    vecs[7]  = '{{5'd7, 5'd2}, 5'd0, 1'b0, 1'b0, 10'd0, 5'd7, 1'b1, 2'b00, 2'b00, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0000};
    vecs[8]  = '{{5'd0, 5'd0}, 5'd0, 1'b0, 1'b0, 10'd0, 5'd0, 1'b1, 2'b01, 2'b00, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0000};
    vecs[9]  = '{{5'd7, 5'd2}, 5'd0, 1'b0, 1'b0, 10'd0, 5'd7, 1'b0, 2'b01, 2'b00, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0000};
    vecs[10] = '{{5'd1, 5'd7}, 5'd0, 1'b0, 1'b0, 10'd0, 5'd7, 1'b1, 2'b01, 2'b00, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b1, 4'b0000};
    vecs[11] = '{10'd0, 5'd0, 1'b0, 1'b0, 10'd0, 5'd0, 1'b0, 2'b00, 2'b01, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1, 4'b0000};
    vecs[12] = '{{5'd7, 5'd2}, 5'd0, 1'b0, 1'b0, 10'd0, 5'd7, 1'b1, 2'b01, 2'b10, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b1, 4'b0000};
    vecs[13] = '{10'd0, 5'd0, 1'b0, 1'b0, {5'd0, 5'd8}, 5'd0, 1'b0, 2'b00, 2'b11, 5'd0, 1'b0, 5'd8, 1'b1, 1'b0, 1'b1, 1'b1, 4'b0001};

    // Reset state, with inputs that would otherwise forward and stall.
    rst = 1'b1;
    idle();
    hz.rs_e = {5'd0, 5'd5}; hz.rd_m = 5'd5; hz.regwrite_m = 1'b1;
    hz.rs_d = {5'd0, 5'd7}; hz.rd_e = 5'd7; hz.regwrite_e = 1'b1; hz.result_src_e = RES_LOAD;
    #2;
    chk_ctl("reset", 1'b0, 1'b1, 1'b1);
    check("reset fwd_e", 32'(hz.fwd_e), 32'h0);
    check("reset busy", 32'(hz.mdu_busy), 32'h0);
    check("reset wb_valid", 32'(hz.mdu_wb_valid), 32'h0);
    check("reset wb_rd", 32'(hz.mdu_wb_rd), 32'h0);
    next_cycle();
    next_cycle();
    rst = 1'b0;
    idle();

    for (int i = 0; i < 14; i++) begin
      next_cycle();
      hz.rs_d = vecs[i].rs_d; hz.rd_d = vecs[i].rd_d; hz.regwrite_d = vecs[i].rwd;
      hz.mdu_op_d = vecs[i].mdud; hz.rs_e = vecs[i].rs_e; hz.rd_e = vecs[i].rd_e;
      hz.regwrite_e = vecs[i].rwe; hz.result_src_e = vecs[i].rse; hz.mdu_start_e = 1'b0;
      hz.pc_src_e = vecs[i].pcs; hz.rd_m = vecs[i].rd_m; hz.regwrite_m = vecs[i].rwm;
      hz.rd_w = vecs[i].rd_w; hz.regwrite_w = vecs[i].rww;
      #1;
      chk_ctl($sformatf("vec%0d", i), vecs[i].e_stall, vecs[i].e_fd, vecs[i].e_fe);
      check($sformatf("vec%0d fwd_e", i), 32'(hz.fwd_e), 32'(vecs[i].e_fwd));
    end

    // Load-use then W forwarding next cycle.
    next_cycle();
    idle();
    hz.rd_e = 5'd7; hz.regwrite_e = 1'b1; hz.result_src_e = RES_LOAD; hz.rs_d = {5'd7, 5'd0};
    #1;
    chk_ctl("lu stall", 1'b1, 1'b0, 1'b1);
    next_cycle();
    idle();
    hz.rs_e = {5'd7, 5'd0}; hz.rd_w = 5'd7; hz.regwrite_w = 1'b1;
    #1;
    chk_ctl("lu after", 1'b0, 1'b0, 1'b0);
    check("lu fwd W", 32'(hz.fwd_e), 32'b0100);

    // MDU RAW: start x9 at t, dependent in D t+1..t+4.
    start_mdu(5'd9);
    check("raw t stall", 32'(hz.stall_f), 32'h0);
    check("raw t busy", 32'(hz.mdu_busy), 32'h0);
    for (int k = 1; k <= 4; k++) begin
      next_cycle();
      idle();
      hz.rs_d = {5'd0, 5'd9};
      #1;
      check($sformatf("raw t+%0d stall", k), 32'(hz.stall_d), 32'(k <= 3));
      check($sformatf("raw t+%0d wb_valid", k), 32'(hz.mdu_wb_valid), 32'(k == 3));
      check($sformatf("raw t+%0d busy", k), 32'(hz.mdu_busy), 32'(k <= 3));
      if (k == 3) check("raw wb_rd", 32'(hz.mdu_wb_rd), 32'd9);
    end

    // Structural: second MDU op waits in D until the counter reaches 1.
    start_mdu(5'd10);
    for (int k = 1; k <= 3; k++) begin
      next_cycle();
      idle();
      hz.mdu_op_d = 1'b1; hz.rd_d = 5'd11; hz.regwrite_d = 1'b1;
      #1;
      check($sformatf("struct t+%0d stall", k), 32'(hz.stall_f), 32'(k <= 2));
      check($sformatf("struct t+%0d wb_valid", k), 32'(hz.mdu_wb_valid), 32'(k == 3));
    end
    start_mdu(5'd11);
    check("struct t+4 busy", 32'(hz.mdu_busy), 32'h0);
    check("struct t+4 stall", 32'(hz.stall_f), 32'h0);
    for (int k = 5; k <= 8; k++) begin
      next_cycle();
      idle();
      #1;
      check($sformatf("struct t+%0d busy", k), 32'(hz.mdu_busy), 32'(k <= 7));
      check($sformatf("struct t+%0d wb_valid", k), 32'(hz.mdu_wb_valid), 32'(k == 7));
      if (k == 7) check("struct wb_rd", 32'(hz.mdu_wb_rd), 32'd11);
    end

    // WAW with a coinciding branch; MDU still completes.
    start_mdu(5'd12);
    for (int k = 1; k <= 4; k++) begin
      next_cycle();
      idle();
      hz.rd_d = 5'd12; hz.regwrite_d = 1'b1;
      if (k == 1) hz.pc_src_e = 2'b01;
      #1;
      chk_ctl($sformatf("waw t+%0d", k), k <= 3, k == 1, k <= 3);
      check($sformatf("waw t+%0d wb_valid", k), 32'(hz.mdu_wb_valid), 32'(k == 3));
      if (k == 3) check("waw wb_rd", 32'(hz.mdu_wb_rd), 32'd12);
    end

    // Reset at t+2 of an MDU op.
    start_mdu(5'd13);
    next_cycle();
    idle();
    hz.rs_d = {5'd13, 5'd0};
    #1;
    check("rstmid t+1 stall", 32'(hz.stall_f), 32'h1);
    next_cycle();
    hz.rs_e = {5'd0, 5'd5}; hz.rd_m = 5'd5; hz.regwrite_m = 1'b1;
    rst = 1'b1;
    #1;
    chk_ctl("rstmid t+2", 1'b0, 1'b1, 1'b1);
    check("rstmid t+2 busy", 32'(hz.mdu_busy), 32'h0);
    check("rstmid t+2 fwd_e", 32'(hz.fwd_e), 32'h0);
    next_cycle();
    check("rstmid t+3 wb_valid", 32'(hz.mdu_wb_valid), 32'h0);
    rst = 1'b0;
    #1;
    check("rstmid release stall", 32'(hz.stall_f), 32'h0);
    check("rstmid release fwd_e", 32'(hz.fwd_e), 32'b0010);
    for (int k = 0; k < 3; k++) begin
      next_cycle();
      #1;
      check($sformatf("rstmid post%0d wb_valid", k), 32'(hz.mdu_wb_valid), 32'h0);
      check($sformatf("rstmid post%0d stall", k), 32'(hz.stall_d), 32'h0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
